// File: rtl/qspi_mux_arbiter_pkg.sv
// Shared encodings for the two-requester QSPI port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qspi_mux_arbiter_pkg;

  // Transaction phases of the shared downstream port.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } state_e;

  // Requester identity as driven on out_src and kept as the round-robin history.
  localparam logic SRC_1 = 1'b0;
  localparam logic SRC_2 = 1'b1;

endpackage

// File: rtl/qspi_mux_arbiter.sv
// Round-robin arbiter sharing one QSPI transaction port between two requesters, with per-transaction timeout.
// Latency: request in IDLE at N -> out_valid at N+1; out_done at M -> ack at M+1, IDLE at M+2.
// Backpressure: holds out_valid/out_data stable until out_ready; the loser keeps its request pending.
module qspi_mux_arbiter
  import qspi_mux_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CW      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_1,
  input  logic [31:0] data_1,
  input  logic        req_2,
  input  logic [31:0] data_2,
  output logic        ack_1,
  output logic        ack_2,
  output logic        gnt_1,
  output logic        gnt_2,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  input  logic        out_done,
  output logic        timeout_err,
  input  logic        clear_err
);

  state_e        state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic          src_q, src_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          pick;

  // Last allowed WAIT_DONE count; reaching it without out_done aborts the transaction.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // State and datapath registers; reset abandons any transaction in flight without an ack.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      src_q   <= SRC_1;
      last_q  <= SRC_2;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Arbitration pick, transaction sequencing, timeout counting and sticky error update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pick    = SRC_1;

    // A timeout in the same cycle overrides the clear below.
    if (clear_err) err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_1 || req_2) begin
          // On a tie the requester that did not win last time goes next.
          if (req_1 && req_2) pick = ~last_q;
          else                pick = req_1 ? SRC_1 : SRC_2;
          data_d  = (pick == SRC_2) ? data_2 : data_1;
          src_d   = pick;
          last_d  = pick;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // No timeout while the downstream has not yet taken the command.
        if (out_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        if (out_done) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ownership, handshake and ack decode straight from the registered state.
  assign gnt_1       = (state_q != ST_IDLE) && (src_q == SRC_1);
  assign gnt_2       = (state_q != ST_IDLE) && (src_q == SRC_2);
  assign ack_1       = (state_q == ST_RELEASE) && (src_q == SRC_1);
  assign ack_2       = (state_q == ST_RELEASE) && (src_q == SRC_2);
  assign out_valid   = (state_q == ST_ISSUE);
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_qspi_mux_arbiter.sv
// Self-checking bench for qspi_mux_arbiter: directed scenarios plus randomized transactions.
// Expectations come from a transaction-level model (winner choice, event cycle offsets, sticky error).
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_qspi_mux_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_1 = 1'b0, req_2 = 1'b0;
  logic [31:0] data_1 = '0, data_2 = '0;
  logic        out_ready = 1'b0, out_done = 1'b0, clear_err = 1'b0;
  logic        ack_1, ack_2, gnt_1, gnt_2, out_valid, out_src, timeout_err;
  logic [31:0] out_data;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: who won the previous tie-relevant grant, and the sticky error.
  bit m_last;
  bit m_err;

  qspi_mux_arbiter #(.TIMEOUT(TO), .CW(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_1(req_1), .data_1(data_1), .req_2(req_2), .data_2(data_2),
    .ack_1(ack_1), .ack_2(ack_2), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .out_done(out_done),
    .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnt_code(input bit w);
    return w ? 32'd2 : 32'd1;
  endfunction

  // One full transaction starting from an idle port. done_dly < 0 means the downstream never completes.
  task automatic run_txn(input bit r1, input bit r2, input logic [31:0] d1, input logic [31:0] d2,
                         input int rdy_dly, input int done_dly, input bit clr_pre, input bit clr_same);
    bit          w;
    logic [31:0] wd;
    bit          ack_now;
    bit          finished;
    tick();
    chk("idle_gnt", 32'({gnt_2, gnt_1}), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    req_1 = r1; req_2 = r2; data_1 = d1; data_2 = d2; clear_err = clr_pre;
    if (r1 && r2) w = ~m_last;
    else          w = r2;
    m_last = w;
    wd = w ? d2 : d1;
    if (clr_pre) m_err = 1'b0;
    tick();
    clear_err = 1'b0;
    chk("iss_valid", 32'(out_valid), 32'd1);
    chk("iss_data", out_data, wd);
    chk("iss_src", 32'(out_src), 32'(w));
    chk("iss_gnt", 32'({gnt_2, gnt_1}), gnt_code(w));
    chk("iss_err", 32'(timeout_err), 32'(m_err));
    // Stall: late data changes and stray out_done must not disturb the held command.
    for (int i = 0; i < rdy_dly; i++) begin
      out_ready = 1'b0;
      out_done  = ($urandom_range(0, 3) == 0);
      data_1    = $urandom;
      data_2    = $urandom;
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, wd);
    end
    out_ready = 1'b1;
    out_done  = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("wait_valid", 32'(out_valid), 32'd0);
    chk("wait_gnt", 32'({gnt_2, gnt_1}), gnt_code(w));
    // Now at WAIT_DONE offset 0; ack expected at offset done_dly+1, or TO on timeout.
    finished = 1'b0;
    for (int k = 0; k <= TO && !finished; k++) begin
      out_done  = (done_dly == k);
      clear_err = clr_same && (done_dly < 0) && (k == TO - 1);
      tick();
      out_done  = 1'b0;
      clear_err = 1'b0;
      ack_now = (done_dly >= 0) ? (k == done_dly) : (k == TO - 1);
      if (ack_now) begin
        if (done_dly < 0) m_err = 1'b1;
        chk("ack", 32'({ack_2, ack_1}), gnt_code(w));
        chk("ack_err", 32'(timeout_err), 32'(m_err));
        finished = 1'b1;
      end else begin
        chk("no_ack", 32'({ack_2, ack_1}), 32'd0);
      end
    end
    if (!finished) chk("ack_bound", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int r, dd;
    m_last = 1'b1;
    m_err  = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 32'({gnt_2, gnt_1}), 32'd0);
    chk("rst_ack", 32'({ack_2, ack_1}), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    resetn = 1'b1;

    // Simultaneous requests from reset: strict alternation starting with requester 1.
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 32'h01020304, 32'hAABBCCDD, 0, $urandom_range(0, TO - 1), 1'b0, 1'b0);

    // Single request, out_done five cycles after acceptance.
    run_txn(1'b1, 1'b0, 32'h01020304, 32'h0, 0, 4, 1'b0, 1'b0);
    // Long backpressure.
    run_txn(1'b0, 1'b1, 32'h11111111, 32'h22222222, 20, 3, 1'b0, 1'b0);
    // Timeout with a clear in the same cycle as the set.
    run_txn(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 2, -1, 1'b0, 1'b1);
    // Error stays sticky across a clean transaction.
    run_txn(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 0, 2, 1'b0, 1'b0);
    // Clear, then out_done exactly on the last allowed count.
    run_txn(1'b1, 1'b1, 32'h12345678, 32'h87654321, 1, TO - 1, 1'b1, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(1, 3);
      dd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_txn(r[0], r[1], $urandom, $urandom, $urandom_range(0, 4), dd,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of WAIT_DONE.
    tick();
    req_1 = 1'b1; req_2 = 1'b0; data_1 = 32'h5A5A5A5A;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mr_wait_valid", 32'(out_valid), 32'd0);
    resetn = 1'b0;
    tick();
    chk("mr_gnt", 32'({gnt_2, gnt_1}), 32'd0);
    chk("mr_ack", 32'({ack_2, ack_1}), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", out_data, 32'd0);
    chk("mr_err", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    req_1 = 1'b1; req_2 = 1'b1; data_1 = 32'h01020304; data_2 = 32'hAABBCCDD;
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    chk("mr_tie_src", 32'(out_src), 32'd0);
    chk("mr_tie_gnt", 32'({gnt_2, gnt_1}), 32'd1);
    chk("mr_tie_data", out_data, 32'h01020304);
    chk("mr_no_ack", 32'({ack_2, ack_1}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_mux_arbiter.md
Name: qspi_mux_arbiter

Overview:
- Shares one downstream QSPI transaction port between two requesters (requester 1, requester 2), each presenting a level request plus a 32-bit command word.
- Round-robin arbitration; grant held for one complete transaction (issue handshake, then completion).
- Per-transaction timeout protects against a hung downstream.
- Sits between the AXI-lite test/config registers and the QSPI mux datapath.

Parameters:
- TIMEOUT, 1024, max cycles in WAIT_DONE before abort; legal range 2..65535.
- CW, 16, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req_1  in  1  requester 1 level request; held until ack_1
- data_1  in  32  requester 1 command word
- req_2  in  1  requester 2 level request
- data_2  in  32  requester 2 command word
- ack_1  out  1  one-cycle pulse: requester 1 transaction finished (ok or timeout)
- ack_2  out  1  one-cycle pulse for requester 2
- gnt_1  out  1  high while requester 1 owns downstream
- gnt_2  out  1  high while requester 2 owns downstream
- out_valid  out  1  command valid to downstream
- out_data  out  32  latched command word
- out_src  out  1  0 = requester 1, 1 = requester 2
- out_ready  in  1  downstream accepts command when out_valid & out_ready
- out_done  in  1  downstream transaction complete pulse
- timeout_err  out  1  sticky: a transaction was aborted by timeout
- clear_err  in  1  clears timeout_err

Behaviour:
- Reset: state IDLE; ack_1, ack_2, gnt_1, gnt_2, out_valid, out_src, timeout_err = 0; out_data = 0; counter = 0; last = requester 2, so requester 1 wins the first tie.
- Reset mid-operation: abandon the transaction immediately; no ack issued.
- IDLE:
  - req_1 xor req_2: grant that requester.
  - Both set: grant the one not equal to last.
  - On grant: latch data_x into out_data, set out_src, gnt_x, and last; go ISSUE.
- ISSUE:
  - out_valid = 1.
  - When out_ready = 1: drop out_valid, clear counter, go WAIT_DONE.
  - Waits indefinitely for out_ready; timeout does not apply here.
- WAIT_DONE:
  - Counter increments each cycle.
  - out_done = 1: go RELEASE.
  - Else if counter == TIMEOUT-1: set timeout_err, go RELEASE.
  - out_done takes priority when it coincides with the timeout cycle; no error is flagged.
- RELEASE:
  - One cycle: ack_x = 1, gnt_x deasserts at end of cycle; go IDLE.
- out_done outside WAIT_DONE is ignored.
- Request changes: data_x and req_x changes after the grant are ignored; the command is latched.
- Requester still asserting req_x in the cycle after ack_x is a new request, arbitrated normally.
- Latency:
  - Request seen in IDLE at cycle N: out_valid at N+1.
  - out_ready at cycle N+1: WAIT_DONE from N+2.
  - out_done at cycle M: ack at M+1, IDLE at M+2.
  - Minimum back-to-back grant spacing is 4 cycles.
- Ungranted requester: its req is not dropped; it waits, and the one-hot grant bounds its wait to one transaction.
- clear_err:
  - Clears timeout_err next cycle.
  - Set and clear in the same cycle: set wins.
- Invariants: gnt_1 & gnt_2 never both 1; out_valid only in ISSUE; at most one ack per grant.

Decomposition:
- Shared package holds the state encoding (IDLE, ISSUE, WAIT_DONE, RELEASE) and the source encodings SRC_1 = 0, SRC_2 = 1.
- No sub-module needed; arbitration is a single combinational pick inside the FSM.
- Optional sub-module: rr_pick2 (2-way round-robin selector) if reused elsewhere.

Test Plan:
- Single request: req_1 = 1, data_1 = 0x01020304, out_ready tied high, out_done 5 cycles after accept.
  - Required: out_valid one cycle after req, out_data = 0x01020304, out_src = 0, ack_1 one cycle after out_done, no timeout_err.
- Simultaneous requests from reset: req_1 = req_2 = 1, held after ack.
  - Required: grants alternate 1, 2, 1, 2 over 4 transactions; out_data alternates 0x01020304 and 0xAABBCCDD.
- Backpressure: out_ready low for 20 cycles.
  - Required: out_valid held high and out_data stable; no timeout.
  - Then out_ready = 1: WAIT_DONE entered next cycle.
- Timeout: TIMEOUT = 8, never assert out_done.
  - Required: ack pulse exactly 8 cycles after WAIT_DONE entry; timeout_err = 1 and stays.
  - Then clear_err: timeout_err = 0.
- Done/timeout coincidence: out_done on the counter == TIMEOUT-1 cycle.
  - Required: ack, timeout_err stays 0.
- Mid-transaction reset: resetn low in WAIT_DONE.
  - Required: next cycle all outputs 0, no ack.
  - After release: requester 1 wins a tie.
